// File: rtl/fifo_merge_reader_pkg.sv
// rtl/fifo_merge_reader_pkg.sv - state encoding shared by the merge reader and FIFO_merge debug decode
package fifo_merge_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/burst_word_packer.sv
// rtl/burst_word_packer.sv - pairs burst words into double-width beats and checks the increment sequence
module burst_word_packer #(
  parameter int n_bits = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic                  flush,
  input  logic [n_bits-1:0]     word,
  output logic                  pending,
  output logic                  mismatch,
  output logic [2*n_bits-1:0]   data_out,
  output logic                  out_valid,
  output logic                  odd
);

  logic [n_bits-1:0] low_word;
  logic [n_bits-1:0] prev_word;
  logic              have_prev;

  // The first word of a burst has no predecessor and is never a mismatch.
  assign mismatch = accept && have_prev && (word != prev_word + n_bits'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_word  <= '0;
      prev_word <= '0;
      have_prev <= 1'b0;
      pending   <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
      odd       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      odd       <= 1'b0;
      if (clear) begin
        low_word  <= '0;
        prev_word <= '0;
        have_prev <= 1'b0;
        pending   <= 1'b0;
      end else if (accept) begin
        prev_word <= word;
        have_prev <= 1'b1;
        if (!pending) begin
          low_word <= word;
          pending  <= 1'b1;
        end else begin
          data_out  <= {word, low_word};
          out_valid <= 1'b1;
          low_word  <= '0;
          pending   <= 1'b0;
        end
      end else if (flush) begin
        data_out  <= {{n_bits{1'b0}}, low_word};
        out_valid <= 1'b1;
        odd       <= 1'b1;
        low_word  <= '0;
        pending   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_merge_reader.sv
// rtl/fifo_merge_reader.sv - read-side burst controller for the merge FIFO
module fifo_merge_reader
  import fifo_merge_reader_pkg::*;
#(
  parameter int n_bits         = 4,
  parameter int max_words      = 16,
  parameter int timeout_cycles = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [n_bits-1:0]                 Data_in,
  input  logic                              in_valid,
  input  logic                              done_in,
  output logic                              start,
  output logic [2*n_bits-1:0]               Data_out,
  output logic                              out_valid,
  output logic                              odd,
  output logic [$clog2(max_words+1)-1:0]    word_count,
  output logic                              seq_error,
  output logic                              overrun,
  output logic                              timeout,
  output logic                              burst_done,
  output logic [2:0]                        state_out
);

  localparam int wc_w = $clog2(max_words + 1);
  localparam int ic_w = $clog2(timeout_cycles + 1);

  state_t            state, state_next;
  logic [ic_w-1:0]   idle_count;
  logic              clear, accept, flush, idle_inc, set_over, set_to;
  logic              pending, mismatch;

  burst_word_packer #(.n_bits(n_bits)) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .accept    (accept),
    .flush     (flush),
    .word      (Data_in),
    .pending   (pending),
    .mismatch  (mismatch),
    .data_out  (Data_out),
    .out_valid (out_valid),
    .odd       (odd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accept     = 1'b0;
    flush      = 1'b0;
    idle_inc   = 1'b0;
    set_over   = 1'b0;
    set_to     = 1'b0;
    case (state)
      ST_IDLE: if (enable) state_next = ST_START;
      ST_START: begin
        clear      = 1'b1;
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (in_valid && word_count == wc_w'(max_words)) begin
          set_over   = 1'b1;
          state_next = ST_DONE;
        end else begin
          accept = in_valid;
          // A word accepted alongside done_in toggles whether a half-pair is left over.
          if (done_in) begin
            state_next = (pending ^ in_valid) ? ST_FLUSH : ST_DONE;
          end else if (!in_valid) begin
            idle_inc = 1'b1;
            if (idle_count == ic_w'(timeout_cycles - 1)) begin
              set_to     = 1'b1;
              state_next = pending ? ST_FLUSH : ST_DONE;
            end
          end
        end
      end
      ST_FLUSH: begin
        flush      = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start      <= 1'b0;
      burst_done <= 1'b0;
      word_count <= '0;
      idle_count <= '0;
      seq_error  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      start      <= (state_next == ST_CAPTURE);
      burst_done <= (state_next == ST_DONE);
      if (clear) begin
        word_count <= '0;
        idle_count <= '0;
        seq_error  <= 1'b0;
        overrun    <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        if (accept) begin
          word_count <= word_count + wc_w'(1);
          idle_count <= '0;
        end else if (idle_inc) begin
          idle_count <= idle_count + ic_w'(1);
        end
        if (mismatch) seq_error <= 1'b1;
        if (set_over) overrun   <= 1'b1;
        if (set_to)   timeout   <= 1'b1;
      end
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_fifo_merge_reader.sv
// tb/tb_fifo_merge_reader.sv - scoreboard bench for fifo_merge_reader
module tb_fifo_merge_reader;

  localparam int NB  = 4;
  localparam int MW  = 16;
  localparam int TO  = 32;
  localparam int WCW = $clog2(MW + 1);

  logic            clock = 1'b0;
  logic            reset, enable, in_valid, done_in;
  logic [NB-1:0]   data_in;
  logic            start, out_valid, odd, seq_error, overrun, timeout, burst_done;
  logic [2*NB-1:0] data_out;
  logic [WCW-1:0]  word_count;
  logic [2:0]      state_out;

  fifo_merge_reader #(.n_bits(NB), .max_words(MW), .timeout_cycles(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .Data_in    (data_in),
    .in_valid   (in_valid),
    .done_in    (done_in),
    .start      (start),
    .Data_out   (data_out),
    .out_valid  (out_valid),
    .odd        (odd),
    .word_count (word_count),
    .seq_error  (seq_error),
    .overrun    (overrun),
    .timeout    (timeout),
    .burst_done (burst_done),
    .state_out  (state_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       odd;
  } beat_t;

  beat_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    beat_t e;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL beat_unexpected: got data=0x%0h odd=%0b expected no beat", data_out, odd);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 32'(data_out), 32'(e.data));
        check("beat_odd", 32'(odd), 32'(e.odd));
      end
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic o);
    beat_t b;
    b.data = d;
    b.odd  = o;
    exp_q.push_back(b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_data_out"}, 32'(data_out), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_odd"}, 32'(odd), 0);
    check({tag, "_word_count"}, 32'(word_count), 0);
    check({tag, "_seq_error"}, 32'(seq_error), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_burst_done"}, 32'(burst_done), 0);
    check({tag, "_state_out"}, 32'(state_out), 0);
  endtask

  task automatic start_burst();
    @(posedge clock); #1;
    check("idle_before_enable", 32'(state_out), 0);
    enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    check("state_start", 32'(state_out), 1);
    check("start_low_in_start", 32'(start), 0);
    @(posedge clock); #1;
    check("start_rises", 32'(start), 1);
    check("state_capture", 32'(state_out), 2);
    check("cleared_word_count", 32'(word_count), 0);
    check("cleared_seq_error", 32'(seq_error), 0);
    check("cleared_overrun", 32'(overrun), 0);
    check("cleared_timeout", 32'(timeout), 0);
  endtask

  task automatic send_word(input logic [NB-1:0] w, input logic d);
    data_in  = w;
    in_valid = 1'b1;
    done_in  = d;
    @(posedge clock); #1;
    in_valid = 1'b0;
    done_in  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int wc, input logic se, input logic ov, input logic to);
    int n = 0;
    while (!burst_done && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!burst_done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_burst_done: got no strobe within 100 cycles expected strobe", tag);
    end else begin
      check({tag, "_word_count"}, 32'(word_count), 32'(wc));
      check({tag, "_seq_error"}, 32'(seq_error), 32'(se));
      check({tag, "_overrun"}, 32'(overrun), 32'(ov));
      check({tag, "_timeout"}, 32'(timeout), 32'(to));
      check({tag, "_start_low"}, 32'(start), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    done_in  = 1'b0;
    data_in  = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // basic burst 3,4,5,6
    start_burst();
    push_beat(8'h43, 1'b0);
    push_beat(8'h65, 1'b0);
    send_word(4'h3, 1'b0);
    send_word(4'h4, 1'b0);
    send_word(4'h5, 1'b0);
    send_word(4'h6, 1'b1);
    wait_done("basic", 4, 0, 0, 0);

    // odd burst wrapping F -> 0
    start_burst();
    push_beat(8'hFE, 1'b0);
    push_beat(8'h00, 1'b1);
    send_word(4'hE, 1'b0);
    send_word(4'hF, 1'b0);
    send_word(4'h0, 1'b1);
    wait_done("wrap", 3, 0, 0, 0);

    // sequence error 1,2,7
    start_burst();
    push_beat(8'h21, 1'b0);
    push_beat(8'h07, 1'b1);
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    check("seq_ok_before_bad", 32'(seq_error), 0);
    send_word(4'h7, 1'b1);
    check("seq_error_set", 32'(seq_error), 1);
    wait_done("seqerr", 3, 1, 0, 0);

    // overrun: 17 words, no done_in
    start_burst();
    for (int i = 0; i < 8; i++) push_beat({4'(2 * i + 1), 4'(2 * i)}, 1'b0);
    for (int i = 0; i < 17; i++) send_word(4'(i), 1'b0);
    wait_done("overrun", 16, 0, 1, 0);

    // timeout after one word
    start_burst();
    push_beat(8'h05, 1'b1);
    send_word(4'h5, 1'b0);
    repeat (TO - 1) @(posedge clock);
    #1;
    check("timeout_not_yet", 32'(timeout), 0);
    @(posedge clock); #1;
    check("timeout_set", 32'(timeout), 1);
    check("timeout_flush_state", 32'(state_out), 3);
    wait_done("timeout", 1, 0, 0, 1);

    // reset mid-burst after three words
    start_burst();
    push_beat(8'h21, 1'b0);
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    send_word(4'h3, 1'b0);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clock); #1;
    reset = 1'b0;

    start_burst();
    push_beat(8'h98, 1'b0);
    send_word(4'h8, 1'b0);
    send_word(4'h9, 1'b1);
    wait_done("after_reset", 2, 0, 0, 0);

    repeat (4) @(posedge clock);
    #1;
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
